// File: rtl/fan_mode_controller.sv
// fan_mode_controller
//
// Turns single-cycle debounced button pulses into fan behaviour. A mode FSM
// (OFF/LOW/MID/HIGH) selects the duty of a registered PWM output and drives
// the mode LEDs. With FAN_TIMER_EN defined, an auto-off countdown timer is
// added. Without it, the timer button is ignored and o_timer_remain is 0.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_btn_speed    pulse: advance speed OFF->LOW->MID->HIGH->LOW
//   i_btn_off      pulse: go OFF and clear the timer (has priority)
//   i_btn_timer    pulse: cycle timer preset 0->3->5->7->0 (FAN_TIMER_EN only)
//   o_pwm          registered PWM to the fan driver
//   o_mode         0=OFF 1=LOW 2=MID 3=HIGH
//   o_led          one-hot {HIGH,MID,LOW}, 3'b000 when OFF
//   o_timer_remain remaining timer units, 0 = timer inactive
//
// Optional feature macro: FAN_TIMER_EN
module fan_mode_controller #(
  parameter int PWM_PERIOD = 100,
  parameter int DUTY_LOW   = 30,
  parameter int DUTY_MID   = 60,
  parameter int DUTY_HIGH  = 90,
  parameter int TIMER_TICK = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_speed,
  input  logic       i_btn_off,
  input  logic       i_btn_timer,
  output logic       o_pwm,
  output logic [1:0] o_mode,
  output logic [2:0] o_led,
  output logic [3:0] o_timer_remain
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_LOW  = 2'd1,
    MODE_MID  = 2'd2,
    MODE_HIGH = 2'd3
  } mode_t;

  localparam int CNT_W  = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  // One extra bit so a duty equal to the period still compares correctly.
  localparam int DUTY_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  mode_t            mode;
  mode_t            next_mode;
  logic [CNT_W-1:0] pwm_cnt;
  logic             expire;

  function automatic logic [DUTY_W-1:0] duty_of(input mode_t m);
    case (m)
      MODE_LOW:  duty_of = DUTY_W'(DUTY_LOW);
      MODE_MID:  duty_of = DUTY_W'(DUTY_MID);
      MODE_HIGH: duty_of = DUTY_W'(DUTY_HIGH);
      default:   duty_of = {DUTY_W{1'b0}};
    endcase
  endfunction

  function automatic logic [2:0] led_of(input mode_t m);
    case (m)
      MODE_LOW:  led_of = 3'b001;
      MODE_MID:  led_of = 3'b010;
      MODE_HIGH: led_of = 3'b100;
      default:   led_of = 3'b000;
    endcase
  endfunction

`ifdef FAN_TIMER_EN
  localparam int TICK_W = (TIMER_TICK > 1) ? $clog2(TIMER_TICK) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TIMER_TICK - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic [3:0]        preset;
  logic [3:0]        remain;
  logic              timer_press;

  function automatic logic [3:0] next_preset(input logic [3:0] p);
    case (p)
      4'd0:    next_preset = 4'd3;
      4'd3:    next_preset = 4'd5;
      4'd5:    next_preset = 4'd7;
      default: next_preset = 4'd0;
    endcase
  endfunction

  // Timer button only counts while the fan is running.
  assign timer_press = i_btn_timer && (mode != MODE_OFF);
  // Last unit elapsing: the fan is forced OFF on this same edge.
  assign expire = (remain == 4'd1) && (tick_cnt == TICK_LAST);
  assign o_timer_remain = remain;

  // Countdown timer: preset cycling, tick counting and expiry/off clearing.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt <= {TICK_W{1'b0}};
      preset   <= 4'd0;
      remain   <= 4'd0;
    end else if (i_btn_off || expire) begin
      tick_cnt <= {TICK_W{1'b0}};
      preset   <= 4'd0;
      remain   <= 4'd0;
    end else if (timer_press) begin
      tick_cnt <= {TICK_W{1'b0}};
      preset   <= next_preset(preset);
      remain   <= next_preset(preset);
    end else if (remain != 4'd0) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= {TICK_W{1'b0}};
        remain   <= remain - 4'd1;
      end else begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end else begin
      tick_cnt <= {TICK_W{1'b0}};
    end
  end
`else
  logic unused_timer_btn;

  assign unused_timer_btn = i_btn_timer;
  assign expire           = 1'b0;
  assign o_timer_remain   = 4'd0;
`endif

  // Next mode: off and expiry dominate the speed button.
  always_comb begin
    next_mode = mode;
    if (i_btn_off || expire) begin
      next_mode = MODE_OFF;
    end else if (i_btn_speed) begin
      case (mode)
        MODE_OFF:  next_mode = MODE_LOW;
        MODE_LOW:  next_mode = MODE_MID;
        MODE_MID:  next_mode = MODE_HIGH;
        MODE_HIGH: next_mode = MODE_LOW;
        default:   next_mode = MODE_OFF;
      endcase
    end else begin
      next_mode = mode;
    end
  end

  // Mode register, decoded outputs, PWM counter and registered PWM compare.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode    <= MODE_OFF;
      o_mode  <= 2'd0;
      o_led   <= 3'b000;
      o_pwm   <= 1'b0;
      pwm_cnt <= {CNT_W{1'b0}};
    end else begin
      mode   <= next_mode;
      // Outputs decode the next state so they change on the same edge as mode.
      o_mode <= next_mode;
      o_led  <= led_of(next_mode);
      o_pwm  <= ({1'b0, pwm_cnt} < duty_of(mode));
      // A mode change starts a fresh period; OFF holds the counter at 0.
      if ((next_mode != mode) || (mode == MODE_OFF)) begin
        pwm_cnt <= {CNT_W{1'b0}};
      end else if (pwm_cnt == CNT_LAST) begin
        pwm_cnt <= {CNT_W{1'b0}};
      end else begin
        pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fan_mode_controller.sv
// Self-checking bench for fan_mode_controller (PWM_PERIOD=10, duty 3/6/9,
// TIMER_TICK=20). Expected per-cycle outputs are queued when stimulus is
// applied and popped as the DUT advances.
module tb_fan_mode_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_speed = 1'b0;
  logic       btn_off = 1'b0;
  logic       btn_timer = 1'b0;
  logic       pwm;
  logic [1:0] mode;
  logic [2:0] led;
  logic [3:0] remain;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0] mode;
    logic [2:0] led;
    logic       pwm;
    logic [3:0] remain;
    logic       chk_pwm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  fan_mode_controller #(
    .PWM_PERIOD(10),
    .DUTY_LOW(3),
    .DUTY_MID(6),
    .DUTY_HIGH(9),
    .TIMER_TICK(20)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_btn_speed(btn_speed),
    .i_btn_off(btn_off),
    .i_btn_timer(btn_timer),
    .o_pwm(pwm),
    .o_mode(mode),
    .o_led(led),
    .o_timer_remain(remain)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] led_for(input logic [1:0] m);
    case (m)
      2'd1:    led_for = 3'b001;
      2'd2:    led_for = 3'b010;
      2'd3:    led_for = 3'b100;
      default: led_for = 3'b000;
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] m, input logic p,
                              input logic [3:0] r, input logic c);
    exp_t x;
    x.mode = m; x.led = led_for(m); x.pwm = p; x.remain = r; x.chk_pwm = c;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++;
    if (mode !== 2'd0 || led !== 3'b000 || pwm !== 1'b0 || remain !== 4'd0) begin
      bad++;
      $display("FAIL reset: mode=%0d led=%b pwm=%b remain=%0d, expected all 0", mode, led, pwm, remain);
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) sb.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1));
    repeat (8) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL reset_idle: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
  endtask

  task automatic test_low_pwm();
    btn_speed = 1'b1; step(); btn_speed = 1'b0;
    total++;
    if (mode !== 2'd1 || led !== 3'b001) begin
      bad++;
      $display("FAIL low_enter: mode=%0d led=%b, expected mode=1 led=001", mode, led);
    end
    for (int k = 0; k < 30; k++) sb.push_back(mk(2'd1, (k % 10) < 3, 4'd0, 1'b1));
    repeat (30) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL low_pwm: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
  endtask

  task automatic test_speed_cycle();
    logic [1:0] seq_mode [4] = '{2'd2, 2'd3, 2'd1, 2'd2};
    int         seq_duty [4] = '{6, 9, 3, 6};
    for (int p = 0; p < 4; p++) begin
      btn_speed = 1'b1; step(); btn_speed = 1'b0;
      total++;
      if (mode !== seq_mode[p] || led !== led_for(seq_mode[p])) begin
        bad++;
        $display("FAIL speed_step%0d: mode=%0d led=%b, expected mode=%0d", p, mode, led, seq_mode[p]);
      end
      for (int k = 0; k < 49; k++) sb.push_back(mk(seq_mode[p], (k % 10) < seq_duty[p], 4'd0, 1'b1));
      repeat (49) begin
        step();
        e = sb.pop_front();
        total++;
        if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
          bad++;
          $display("FAIL speed_pwm%0d: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                   p, mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
        end
      end
    end
  endtask

  task automatic test_off_wins();
    btn_speed = 1'b1; btn_off = 1'b1; step(); btn_speed = 1'b0; btn_off = 1'b0;
    total++;
    if (mode !== 2'd0 || led !== 3'b000) begin
      bad++;
      $display("FAIL off_wins: mode=%0d led=%b, expected mode=0 led=000", mode, led);
    end
    for (int k = 0; k < 20; k++) sb.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1));
    repeat (20) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL off_hold: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] held [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    btn_speed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (mode !== held[k]) begin
        bad++;
        $display("FAIL b2b_speed%0d: mode=%0d, expected %0d", k, mode, held[k]);
      end
    end
    btn_speed = 1'b0;
    for (int k = 0; k < 20; k++) sb.push_back(mk(2'd3, (k % 10) < 9, 4'd0, 1'b1));
    repeat (20) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL b2b_high_pwm: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
    btn_off = 1'b1; step(); step(); btn_off = 1'b0;
    total++;
    if (mode !== 2'd0) begin
      bad++;
      $display("FAIL b2b_off: mode=%0d, expected 0", mode);
    end
    btn_speed = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (mode !== held[k] || led !== led_for(held[k])) begin
        bad++;
        $display("FAIL b2b_wrap%0d: mode=%0d led=%b, expected mode=%0d", k, mode, led, held[k]);
      end
    end
    btn_speed = 1'b0;
    btn_off = 1'b1; step(); btn_off = 1'b0;
  endtask

  task automatic test_timer();
`ifdef FAN_TIMER_EN
    logic [3:0] presets [4] = '{4'd3, 4'd5, 4'd7, 4'd0};
    for (int k = 0; k < 2; k++) begin
      btn_timer = 1'b1; step(); btn_timer = 1'b0;
      total++;
      if (remain !== 4'd0 || mode !== 2'd0) begin
        bad++;
        $display("FAIL timer_in_off: remain=%0d mode=%0d, expected 0 0", remain, mode);
      end
    end
    btn_speed = 1'b1; step(); btn_speed = 1'b0;
    btn_timer = 1'b1; step(); btn_timer = 1'b0;
    total++;
    if (remain !== 4'd3 || mode !== 2'd1) begin
      bad++;
      $display("FAIL timer_load: remain=%0d mode=%0d, expected 3 1", remain, mode);
    end
    for (int j = 1; j <= 65; j++) begin
      int r;
      r = (j >= 60) ? 0 : 3 - j / 20;
      sb.push_back(mk((r != 0) ? 2'd1 : 2'd0, 1'b0, 4'(r), 1'b0));
    end
    repeat (65) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL timer_count: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
    btn_speed = 1'b1; step(); step(); step(); btn_speed = 1'b0;
    for (int k = 0; k < 4; k++) begin
      btn_timer = 1'b1; step(); btn_timer = 1'b0;
      total++;
      if (remain !== presets[k] || mode !== 2'd3) begin
        bad++;
        $display("FAIL timer_preset%0d: remain=%0d mode=%0d, expected %0d 3", k, remain, mode, presets[k]);
      end
    end
`else
    btn_speed = 1'b1; step(); btn_speed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      btn_timer = 1'b1; step(); btn_timer = 1'b0;
      total++;
      if (remain !== 4'd0 || mode !== 2'd1) begin
        bad++;
        $display("FAIL timer_ignored: remain=%0d mode=%0d, expected 0 1", remain, mode);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    btn_off = 1'b1; step(); btn_off = 1'b0;
    btn_speed = 1'b1; step(); step(); step(); btn_speed = 1'b0;
    total++;
    if (mode !== 2'd3) begin
      bad++;
      $display("FAIL reset_mid_setup: mode=%0d, expected 3", mode);
    end
`ifdef FAN_TIMER_EN
    btn_timer = 1'b1; step(); btn_timer = 1'b0;
    repeat (25) step();
    total++;
    if (remain !== 4'd2) begin
      bad++;
      $display("FAIL reset_mid_countdown: remain=%0d, expected 2", remain);
    end
`else
    repeat (25) step();
`endif
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if (mode !== 2'd0 || led !== 3'b000 || pwm !== 1'b0 || remain !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid: mode=%0d led=%b pwm=%b remain=%0d, expected all 0", mode, led, pwm, remain);
    end
    for (int k = 0; k < 80; k++) sb.push_back(mk(2'd0, 1'b0, 4'd0, 1'b1));
    repeat (80) begin
      step();
      e = sb.pop_front();
      total++;
      if (mode !== e.mode || led !== e.led || remain !== e.remain || (e.chk_pwm && pwm !== e.pwm)) begin
        bad++;
        $display("FAIL reset_after: mode=%0d led=%b pwm=%b remain=%0d, expected mode=%0d led=%b pwm=%b remain=%0d",
                 mode, led, pwm, remain, e.mode, e.led, e.pwm, e.remain);
      end
    end
  endtask

  initial begin
    test_reset();
    test_low_pwm();
    test_speed_cycle();
    test_off_wins();
    test_back_to_back();
    test_timer();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
